// File: rtl/shift_in_deserializer_pkg.sv
// Shared constants for the serial-to-parallel receive path.
package shift_in_deserializer_pkg;

    // Plane-row width used by the column-parity datapath.
    localparam int DEFAULT_N = 25;

    function automatic int cnt_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/shift_in_deserializer_shift_in_register.sv
// Left shift register fed from the LSB; restart reloads it with just the incoming bit.
module shift_in_register #(
    parameter int N = 25
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush_i,
    input  logic         en_i,
    input  logic         restart_i,
    input  logic         sin_i,
    output logic [N-1:0] q_o
);

    logic [N-1:0] shreg_q, shreg_d;

    always_comb begin
        shreg_d = shreg_q;
        if (flush_i)
            shreg_d = '0;
        else if (en_i && restart_i)
            shreg_d = {{(N-1){1'b0}}, sin_i};
        else if (en_i)
            shreg_d = {shreg_q[N-2:0], sin_i};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            shreg_q <= '0;
        else
            shreg_q <= shreg_d;
    end

    assign q_o = shreg_q;

endmodule

// File: rtl/shift_in_deserializer.sv
// MSB-first serial receiver: assembles N-bit words and hands them out over valid/ready,
// with a one-word holding register so the next word can shift in during backpressure.
module shift_in_deserializer
    import shift_in_deserializer_pkg::*;
#(
    parameter int N = DEFAULT_N
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         sin,
    input  logic         sin_valid,
    input  logic         sin_sof,
    output logic         sin_ready,
    output logic [N-1:0] out_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         frame_err,
    output logic         busy
);

    localparam int            CW   = cnt_width(N);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic [N-1:0]  data_q, data_d;
    logic          vld_q, vld_d;
    logic          ferr_q, ferr_d;
    logic [N-1:0]  shreg;
    logic          accept, deliver, resync, complete;

    // The completing bit only stalls while a held word is still undelivered;
    // gating with rst keeps every output low while reset is asserted.
    assign sin_ready = rst & ((cnt_q != LAST) | ~vld_q | out_ready);
    assign accept    = sin_valid & sin_ready;
    assign deliver   = vld_q & out_ready;
    assign resync    = accept & sin_sof & (cnt_q != '0);
    assign complete  = accept & ~resync & (cnt_q == LAST);

    shift_in_register #(.N(N)) u_sreg (
        .clk       (clk),
        .rst       (rst),
        .flush_i   (clr),
        .en_i      (accept),
        .restart_i (resync),
        .sin_i     (sin),
        .q_o       (shreg)
    );

    always_comb begin
        cnt_d  = cnt_q;
        data_d = data_q;
        vld_d  = vld_q;
        ferr_d = 1'b0;
        if (clr) begin
            cnt_d = '0;
            vld_d = 1'b0;
        end else begin
            if (resync) begin
                cnt_d  = CW'(1);
                ferr_d = 1'b1;
            end else if (complete) begin
                cnt_d = '0;
            end else if (accept) begin
                cnt_d = cnt_q + CW'(1);
            end
            // A fresh word overrides the delivery so out_valid never bubbles.
            if (complete) begin
                data_d = {shreg[N-2:0], sin};
                vld_d  = 1'b1;
            end else if (deliver) begin
                vld_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q  <= '0;
            data_q <= '0;
            vld_q  <= 1'b0;
            ferr_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            data_q <= data_d;
            vld_q  <= vld_d;
            ferr_q <= ferr_d;
        end
    end

    assign out_data  = data_q;
    assign out_valid = vld_q;
    assign frame_err = ferr_q;
    assign busy      = (cnt_q != '0);

endmodule

// File: tb/tb_shift_in_deserializer.sv
// Directed bench for shift_in_deserializer with a bit-queue reference model checked every cycle.
module tb_shift_in_deserializer;

    localparam int N = 25;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         clr = 1'b0;
    logic         sin = 1'b0;
    logic         sin_valid = 1'b0;
    logic         sin_sof = 1'b0;
    logic         out_ready = 1'b0;
    logic         sin_ready, out_valid, frame_err, busy;
    logic [N-1:0] out_data;

    logic       clr4 = 1'b0, sin4 = 1'b0, v4 = 1'b0, sof4 = 1'b0, r4 = 1'b0;
    logic       rdy4, ov4, fe4, busy4;
    logic [3:0] od4;

    always #5 clk = ~clk;

    shift_in_deserializer #(.N(N)) dut (
        .clk(clk), .rst(rst), .clr(clr), .sin(sin), .sin_valid(sin_valid),
        .sin_sof(sin_sof), .sin_ready(sin_ready), .out_data(out_data),
        .out_valid(out_valid), .out_ready(out_ready), .frame_err(frame_err), .busy(busy)
    );

    shift_in_deserializer #(.N(4)) dut4 (
        .clk(clk), .rst(rst), .clr(clr4), .sin(sin4), .sin_valid(v4),
        .sin_sof(sof4), .sin_ready(rdy4), .out_data(od4),
        .out_valid(ov4), .out_ready(r4), .frame_err(fe4), .busy(busy4)
    );

    int n_chk = 0, n_pass = 0;
    int cyc = 0, ov_cnt = 0, fe_cnt = 0, nr_cnt = 0, ov_first = -1, ov_last = -1;

    // Model: bits received into the current partial word, plus the held word.
    bit           mbits[$];
    logic [N-1:0] m_held;
    logic         m_vld, m_ferr;

    function automatic logic m_ready();
        return rst && !(mbits.size() == N - 1 && m_vld && !out_ready);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
    endtask

    task automatic model_reset();
        mbits.delete();
        m_held = '0;
        m_vld  = 1'b0;
        m_ferr = 1'b0;
    endtask

    task automatic model_edge();
        logic acc, dlv;
        logic [N-1:0] w;
        if (!rst) begin
            model_reset();
        end else if (clr) begin
            mbits.delete();
            m_vld  = 1'b0;
            m_ferr = 1'b0;
        end else begin
            acc    = sin_valid && m_ready();
            dlv    = m_vld && out_ready;
            m_ferr = 1'b0;
            if (acc && sin_sof && mbits.size() != 0) begin
                mbits.delete();
                mbits.push_back(sin);
                m_ferr = 1'b1;
            end else if (acc) begin
                mbits.push_back(sin);
            end
            if (mbits.size() == N) begin
                w = '0;
                for (int i = 0; i < N; i++) w = {w[N-2:0], mbits[i]};
                m_held = w;
                mbits.delete();
                m_vld = 1'b1;
            end else if (dlv) begin
                m_vld = 1'b0;
            end
        end
    endtask

    task automatic check_all();
        chk("sin_ready", 32'(sin_ready), 32'(m_ready()));
        chk("out_valid", 32'(out_valid), 32'(m_vld));
        chk("out_data",  32'(out_data),  32'(m_held));
        chk("frame_err", 32'(frame_err), 32'(m_ferr));
        chk("busy",      32'(busy),      32'(mbits.size() != 0));
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        cyc++;
        check_all();
        if (out_valid) begin
            ov_cnt++;
            if (ov_first < 0) ov_first = cyc;
            ov_last = cyc;
        end
        if (frame_err) fe_cnt++;
        if (!sin_ready) nr_cnt++;
    endtask

    task automatic send_bit(input logic b, input logic sof);
        sin       = b;
        sin_valid = 1'b1;
        sin_sof   = sof;
        step();
        sin_sof   = 1'b0;
    endtask

    task automatic send_range(input logic [N-1:0] w, input int hi);
        for (int i = hi; i >= 0; i--) send_bit(w[i], 1'b0);
    endtask

    task automatic idle();
        sin_valid = 1'b0;
        step();
    endtask

    logic [3:0] words4[$];
    logic [7:0] stream4;

    initial begin
        model_reset();
        #12;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data",  32'(out_data),  32'd0);
        chk("rst_sin_ready", 32'(sin_ready), 32'd0);
        chk("rst_busy",      32'(busy),      32'd0);
        chk("rst_frame_err", 32'(frame_err), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        #1 chk("post_rst_ready", 32'(sin_ready), 32'd1);

        // Basic word
        out_ready = 1'b1;
        send_range(25'h1A55A5A, N - 1);
        chk("basic_valid", 32'(out_valid), 32'd1);
        chk("basic_data",  32'(out_data),  32'h1A55A5A);
        idle();
        chk("basic_valid_drop", 32'(out_valid), 32'd0);

        // Backpressure: second word stalls on its last bit
        out_ready = 1'b0;
        send_range(25'h1FFFFFF, N - 1);
        send_range(25'h0000001, N - 1);
        #1;
        // The loop above issued all 25 bits; the last one must have stalled.
        chk("bp_stall_ready", 32'(sin_ready), 32'd0);
        chk("bp_hold_data",   32'(out_data),  32'h1FFFFFF);
        chk("bp_busy",        32'(busy),      32'd1);
        step();
        chk("bp_still_held",  32'(out_data),  32'h1FFFFFF);
        out_ready = 1'b1;
        #1 chk("bp_ready_comb", 32'(sin_ready), 32'd1);
        step();
        chk("bp_second_data",  32'(out_data),  32'h0000001);
        chk("bp_second_valid", 32'(out_valid), 32'd1);
        idle();

        // Resync: 10 stray bits, then sof + word
        fe_cnt = 0;
        for (int i = 0; i < 10; i++) send_bit(logic'(i % 2), 1'b0);
        send_bit(1'b0, 1'b1);
        chk("resync_ferr_at_sof", 32'(frame_err), 32'd1);
        send_range(25'h0F0F0F0, N - 2);
        chk("resync_data",  32'(out_data),  32'h0F0F0F0);
        chk("resync_valid", 32'(out_valid), 32'd1);
        chk("resync_ferr_count", 32'(fe_cnt), 32'd1);
        idle();

        // Throughput: three back-to-back words
        ov_cnt = 0; nr_cnt = 0; ov_first = -1; ov_last = -1;
        send_range(25'h1555555, N - 1);
        send_range(25'h0AAAAAA, N - 1);
        send_range(25'h1234567, N - 1);
        chk("tp_words",    32'(ov_cnt), 32'd3);
        chk("tp_not_ready", 32'(nr_cnt), 32'd0);
        chk("tp_cadence",  32'(ov_last - ov_first), 32'd50);
        chk("tp_last_data", 32'(out_data), 32'h1234567);
        idle();

        // Reset mid-word
        send_range(25'h1FFFFFF, 11);
        rst = 1'b0;
        sin_valid = 1'b0;
        #1;
        chk("mid_rst_data",  32'(out_data),  32'd0);
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_busy",  32'(busy),      32'd0);
        chk("mid_rst_ready", 32'(sin_ready), 32'd0);
        model_reset();
        step();
        rst = 1'b1;
        send_range(25'h0C3C3C3, N - 1);
        chk("post_rst_word", 32'(out_data), 32'h0C3C3C3);
        idle();

        // Clear with a held word and a partial word
        out_ready = 1'b0;
        send_range(25'h1ABCDEF, N - 1);
        send_range(25'h1FFFFFF, 4);
        chk("pre_clr_valid", 32'(out_valid), 32'd1);
        chk("pre_clr_busy",  32'(busy),      32'd1);
        sin_valid = 1'b0;
        clr = 1'b1;
        step();
        clr = 1'b0;
        chk("clr_valid", 32'(out_valid), 32'd0);
        chk("clr_busy",  32'(busy),      32'd0);
        chk("clr_keeps_data", 32'(out_data), 32'h1ABCDEF);
        out_ready = 1'b1;
        send_range(25'h0000003, N - 1);
        chk("post_clr_word", 32'(out_data), 32'h0000003);
        idle();

        // N=4 instance: 1,0,1,1,0,1,1,0 -> 0xB then 0x6
        r4 = 1'b1;
        stream4 = 8'b1011_0110;
        for (int i = 7; i >= 0; i--) begin
            sin4 = stream4[i];
            v4   = 1'b1;
            step();
            if (ov4) words4.push_back(od4);
        end
        v4 = 1'b0;
        step();
        chk("n4_count", 32'(words4.size()), 32'd2);
        if (words4.size() == 2) begin
            chk("n4_word0", 32'(words4[0]), 32'hB);
            chk("n4_word1", 32'(words4[1]), 32'h6);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/shift_in_deserializer.md
Name: shift_in_deserializer

Overview:
- Receiving end of the MSB-first serial bit stream that the team's left-shift registers emit from their top bit.
- Collects N serial bits into one parallel word and holds it in an output register.
- Delivers the word over a valid/ready handshake.
- Double-buffered: the next word can shift in while the previous word waits for the consumer.
- Sits between a serial link and parallel consumers such as the column-parity datapath (25-bit plane rows).

Parameters:
- N, 25, word width in bits; legal range N >= 2.
- CW, $clog2(N), bit-counter width; derived, not overridden.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous reset, active-low: rst=0 resets immediately; release is synchronous to clk.
- clr  input  1  synchronous flush: drops the partial word and the held word.
- sin  input  1  serial data bit, MSB first.
- sin_valid  input  1  sin carries a bit this cycle.
- sin_sof  input  1  qualifies sin as the first (MSB) bit of a word; only meaningful when sin_valid=1.
- sin_ready  output  1  the bit is accepted this cycle if sin_valid=1.
- out_data  output  N  assembled word; the first bit received ends up in out_data[N-1].
- out_valid  output  1  out_data holds an undelivered word.
- out_ready  input  1  consumer accepts out_data this cycle.
- frame_err  output  1  one-cycle pulse: sof arrived mid-word.
- busy  output  1  partial word in progress (cnt != 0).

Behaviour:
- Reset (rst=0): shreg=0, cnt=0, out_data=0, out_valid=0, frame_err=0. All outputs are 0 during reset, and sin_ready=1 once reset is released.
- Handshake terms:
  - Accept = sin_valid & sin_ready.
  - Deliver = out_valid & out_ready.
- Shift: on accept, shreg <= {shreg[N-2:0], sin} and cnt increments.
- Word completion (accept with cnt==N-1):
  - out_data <= {shreg[N-2:0], sin}, out_valid <= 1, cnt <= 0.
  - Latency: out_valid rises the cycle after the Nth bit is accepted.
- sin_ready = (cnt != N-1) | ~out_valid | out_ready.
  - This is a combinational path from out_ready; it is documented and accepted.
  - A completing bit is stalled only while an undelivered word is still held.
- Simultaneous deliver and complete: out_data loads the new word and out_valid stays 1, so there is no bubble.
- Deliver without complete: out_valid <= 0 and out_data keeps its value.
- out_data stays stable while out_valid=1 and out_ready=0.
- sof handling (accepted bit with sin_sof=1):
  - cnt==0: normal first bit.
  - cnt!=0: partial bits are discarded, shreg <= {{N-1{1'b0}}, sin}, cnt <= 1, and frame_err pulses for one cycle. The held word is unaffected.
- sin_sof is ignored when sin_valid=0 or sin_ready=0.
- Words need not use sof; a bare N-bit run still completes a word.
- clr has priority over shift and deliver: cnt<=0, shreg<=0, out_valid<=0, frame_err<=0. out_data is not cleared.
- rst asserted mid-word or mid-handshake returns every register to its reset value immediately. No partial word survives.
- cnt never exceeds N-1; it wraps to 0 only on completion, clr, or rst.
- busy = (cnt != 0), derived combinationally from registered state.

Decomposition:
- Shared package:
  - Default word width constant (25).
  - Counter-width function/constant.
- One natural sub-module: shift_in_register. It holds a left shift with enable and a synchronous clear that loads {0, sin}. The top level owns the counter, holding register, handshake and frame logic.
- No state-machine typedef is needed; the states are implicit in cnt and out_valid.

Test Plan:
- Basic word, N=25: after reset, send 0x1A5_5A5A MSB first with sin_valid=1 and out_ready=1 -> out_valid=1 for one cycle, the cycle after bit 25, with out_data=0x1A55A5A.
- Backpressure: out_ready=0, send two back-to-back words 0x1FFFFFF and 0x0000001.
  - sin_ready drops at the 25th bit of word 2; out_data holds 0x1FFFFFF.
  - Raise out_ready -> 0x1FFFFFF is delivered, the stalled bit is accepted the same cycle, and the next cycle shows out_data=0x0000001.
- Resync: send 10 bits, then sof plus 25 bits of 0x0F0F0F0 -> frame_err pulses once, at the sof bit, and out_data=0x0F0F0F0.
- Throughput: continuous bits with out_ready=1 -> one word every 25 cycles, sin_ready never deasserts, no gaps in out_valid cadence.
- Reset and clear:
  - rst=0 at bit 12 -> all outputs 0 immediately; the next word assembles correctly from bit 0.
  - clr with out_valid=1 -> out_valid=0 next cycle; busy=0.
- Small instance, N=4: stream 1,0,1,1,0,1,1,0 with out_ready=1 -> words 0xB then 0x6, in order.
